rng_roll_ctrl: RTL

//  Sequencer for the 16-bit LFSR random source in the lab1 random-number core.
//  On i_start it seeds the LFSR, then runs a "roll": it samples the LFSR value

---
 rtl/rng_roll_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/rng_roll_ctrl.sv
// rng_roll_ctrl: seeds the LFSR on start, then samples it at growing intervals (decelerating dice roll) until NUM_UPDATES samples are taken.
module rng_roll_ctrl #(
    parameter int DATA_W        = 4,
    parameter int CNT_W         = 32,
    parameter int BASE_INTERVAL = 5_000_000,
    parameter int INTERVAL_STEP = 2_500_000,
    parameter int NUM_UPDATES   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_lfsr_val,
    output logic              o_lfsr_seed_ld,
    output logic              o_lfsr_step,
    output logic [DATA_W-1:0] o_random_out,
    output logic              o_busy,
    output logic              o_done
);
    localparam int UPD_W = NUM_UPDATES > 1 ? $clog2(NUM_UPDATES) : 1;
    typedef enum logic {IDLE, ROLL} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, interval, interval_n, interval_sat;
    logic [CNT_W:0] interval_sum;
    logic [UPD_W-1:0] upd, upd_n;
    logic [DATA_W-1:0] rand_n;
    logic seed_n, step_n, done_n, expiry;
    assign interval_sum = {1'b0, interval} + (CNT_W+1)'(INTERVAL_STEP);
    // interval grows but must never wrap back to a short period
    assign interval_sat = interval_sum[CNT_W] ? '1 : interval_sum[CNT_W-1:0];
    assign expiry = cnt == interval - CNT_W'(1);
    assign o_busy = state == ROLL;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            interval       <= CNT_W'(BASE_INTERVAL);
            upd            <= '0;
            o_random_out   <= '0;
            o_lfsr_seed_ld <= 1'b0;
            o_lfsr_step    <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            interval       <= interval_n;
            upd            <= upd_n;
            o_random_out   <= rand_n;
            o_lfsr_seed_ld <= seed_n;
            o_lfsr_step    <= step_n;
            o_done         <= done_n;
        end
    end
    // a start request always wins, including over a coincident expiry
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        interval_n = interval;
        upd_n      = upd;
        rand_n     = o_random_out;
        seed_n     = 1'b0;
        step_n     = 1'b0;
        done_n     = 1'b0;
        if (i_start) begin
            state_n    = ROLL;
            cnt_n      = '0;
            interval_n = CNT_W'(BASE_INTERVAL);
            upd_n      = '0;
            seed_n     = 1'b1;
        end else if (state == ROLL) begin
            if (expiry) begin
                rand_n     = i_lfsr_val;
                step_n     = 1'b1;
                cnt_n      = '0;
                upd_n      = upd + 1'b1;
                interval_n = interval_sat;
                state_n    = upd == UPD_W'(NUM_UPDATES - 1) ? IDLE : ROLL;
                done_n     = upd == UPD_W'(NUM_UPDATES - 1);
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end
endmodule
